// File: rtl/display_scan_controller.sv
// display_scan_controller
// Time-multiplexing driver for a 4-digit seven-segment display. It steps a
// 2-bit digit select through 0..3, one slot of COUNT_MAX clocks per digit.
// Each slot opens with BLANK_CYCLES of all-anodes-off dead time, followed by
// the lit phase for the selected digit.
//
// Parameters
//   COUNT_MAX     clocks per digit slot (>= 2)
//   BLANK_CYCLES  dark clocks at the start of each slot (0 .. COUNT_MAX-1)
// Ports
//   clk         rising-edge system clock
//   reset       synchronous, active-high reset
//   enable      1 = scan, 0 = freeze counters and blank the display
//   digit_en    per-digit lit mask, bit i = digit i
//   contador    registered digit select for the nibble mux
//   anodes      registered active-low anode enables, at most one low
//   digit_tick  registered one-cycle pulse on the cycle contador advances
module display_scan_controller #(
   parameter int unsigned COUNT_MAX    = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] digit_en,
   output logic [1:0] contador,
   output logic [3:0] anodes,
   output logic       digit_tick
);

   localparam int unsigned CW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_MAX - 1);
   localparam logic HAS_BLANK = (BLANK_CYCLES != 0);
   // Last count value that still belongs to the blank phase.
   localparam logic [CW-1:0] BLANK_LAST = CW'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BLANK,
      S_LIT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    contador_q, contador_d;
   logic [3:0]    anodes_q, anodes_d;
   logic          tick_q, tick_d;
   logic          in_blank;

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         contador_q <= 2'd0;
         anodes_q   <= 4'hF;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         contador_q <= contador_d;
         anodes_q   <= anodes_d;
         tick_q     <= tick_d;
      end
   end

   // Next state, prescaler and registered-output precompute.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      contador_d = contador_q;
      anodes_d   = 4'hF;
      tick_d     = 1'b0;
      in_blank   = 1'b0;

      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         // Leaving IDLE resumes from the held count without advancing it.
         if (state_q != S_IDLE) begin
            if (cnt_q == CNT_LAST) begin
               cnt_d      = '0;
               contador_d = contador_q + 2'd1;
               tick_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         in_blank = HAS_BLANK && (cnt_d <= BLANK_LAST);
         state_d  = in_blank ? S_BLANK : S_LIT;

         // Anodes follow the next-state select so they switch on the same edge.
         if ((state_d == S_LIT) && digit_en[contador_d]) begin
            anodes_d = ~(4'b0001 << contador_d);
         end
      end
   end

   assign contador   = contador_q;
   assign anodes     = anodes_q;
   assign digit_tick = tick_q;

endmodule
